// File: rtl/gpu_palette_pkg.sv
// Shared palette-stage definitions: memory geometry and the loader state encoding.
package gpu_palette_pkg;

  localparam int PAL_ADDR_W  = 10;
  localparam int PAL_DATA_W  = 16;
  localparam int PAL_ENTRIES = 1024;
  localparam int PAL_CNT_W   = 11;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DATA,
    DRAIN
  } loadState_t;

  function automatic logic countLegal(input logic [PAL_CNT_W-1:0] c);
    return (c != '0) && (c <= PAL_CNT_W'(PAL_ENTRIES));
  endfunction

endpackage

// File: rtl/palette_loader.sv
// Parses host palette bursts (start, count, data...) and drives the palette
// write port one entry per cycle, optionally gated to vertical blanking.
module palette_loader
  import gpu_palette_pkg::*;
#(
  parameter int ADDR_W       = PAL_ADDR_W,
  parameter int DATA_W       = PAL_DATA_W,
  parameter bit VBLANK_GATED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              vblank,
  output logic              pal_we,
  output logic [ADDR_W-1:0] pal_addr,
  output logic [DATA_W-1:0] pal_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loadState_t             state, stateNext;
  logic                   readyReg;
  logic [ADDR_W-1:0]      addr;
  logic [PAL_CNT_W-1:0]   remaining;
  logic [PAL_CNT_W-1:0]   countWord;
  logic                   accept;
  logic                   loadAddr, loadCount, writeBeat;
  logic                   setErr, clrErr, pulseDone;

  assign countWord = s_data[PAL_CNT_W-1:0];

  // Only the DATA state is throttled by vblank; the gate is combinational so
  // a falling vblank stalls the very next edge.
  assign s_ready = readyReg && ((state != DATA) || vblank || !VBLANK_GATED);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadAddr  = 1'b0;
    loadCount = 1'b0;
    writeBeat = 1'b0;
    setErr    = 1'b0;
    clrErr    = 1'b0;
    pulseDone = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          loadAddr = 1'b1;
          clrErr   = 1'b1;
          if (s_last) setErr = 1'b1;
          else        stateNext = COUNT;
        end
        COUNT: begin
          if (s_last) begin
            setErr    = 1'b1;
            stateNext = IDLE;
          end else if (!countLegal(countWord)) begin
            setErr    = 1'b1;
            stateNext = DRAIN;
          end else begin
            loadCount = 1'b1;
            stateNext = DATA;
          end
        end
        DATA: begin
          writeBeat = 1'b1;
          if (remaining == PAL_CNT_W'(1)) begin
            if (s_last) begin
              pulseDone = 1'b1;
              stateNext = IDLE;
            end else begin
              setErr    = 1'b1;
              stateNext = DRAIN;
            end
          end else if (s_last) begin
            setErr    = 1'b1;
            stateNext = IDLE;
          end
        end
        DRAIN: begin
          if (s_last) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readyReg  <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      pal_we    <= 1'b0;
      pal_addr  <= '0;
      pal_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      readyReg <= 1'b1;
      pal_we   <= writeBeat;
      done     <= pulseDone;
      busy     <= (stateNext != IDLE);
      if (loadAddr)       addr <= s_data[ADDR_W-1:0];
      else if (writeBeat) addr <= addr + ADDR_W'(1);
      if (loadCount)      remaining <= countWord;
      else if (writeBeat) remaining <= remaining - PAL_CNT_W'(1);
      if (writeBeat) begin
        pal_addr  <= addr;
        pal_wdata <= s_data;
      end
      // A header that itself carries s_last both clears and re-flags err.
      if (setErr)      err <= 1'b1;
      else if (clrErr) err <= 1'b0;
    end
  end

endmodule
